// File: rtl/stack_queue_pkg.sv
// stack_queue_pkg: shared mode encodings and width helpers for the stack/queue buffer
package stack_queue_pkg;
   localparam logic MODE_LIFO = 1'b0;
   localparam logic MODE_FIFO = 1'b1;
   function automatic int ptr_w(input int n);
      return $clog2(n);
   endfunction
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/stack_queue_mem.sv
// stack_queue_mem: STACK_SIZE x BUS_WIDTH register file, sync write (we/waddr/wdata), async read (raddr/rdata)
module stack_queue_mem
   import stack_queue_pkg::*;
#(
   parameter int BUS_WIDTH  = 16,
   parameter int STACK_SIZE = 16
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [ptr_w(STACK_SIZE)-1:0]   waddr,
   input  logic [ptr_w(STACK_SIZE)-1:0]   raddr,
   input  logic [BUS_WIDTH-1:0]           wdata,
   output logic [BUS_WIDTH-1:0]           rdata
);
   logic [BUS_WIDTH-1:0] mem [STACK_SIZE];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/stack_queue.sv
// stack_queue: LIFO/FIFO buffer; push/pop/data_in in, registered data_out+valid, count, level flags, overflow/underflow pulses
module stack_queue
   import stack_queue_pkg::*;
#(
   parameter int BUS_WIDTH        = 16,
   parameter int STACK_SIZE       = 16,
   parameter int ALMOST_FULL_LVL  = STACK_SIZE - 2,
   parameter int ALMOST_EMPTY_LVL = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           mode,
   input  logic                           push,
   input  logic                           pop,
   input  logic [BUS_WIDTH-1:0]           data_in,
   output logic [BUS_WIDTH-1:0]           data_out,
   output logic                           valid,
   output logic [cnt_w(STACK_SIZE)-1:0]   count,
   output logic                           full,
   output logic                           empty,
   output logic                           almost_full,
   output logic                           almost_empty,
   output logic                           overflow,
   output logic                           underflow
);
   localparam int PW = ptr_w(STACK_SIZE);
   localparam int CW = cnt_w(STACK_SIZE);
   logic [PW-1:0] wr_ptr, rd_ptr, top_ptr, waddr, raddr, wr_next, rd_next;
   logic [BUS_WIDTH-1:0] rdata;
   logic mode_q, m, lifo, push_ok, pop_ok;
   assign full         = count == CW'(STACK_SIZE);
   assign empty        = count == '0;
   assign almost_full  = count >= CW'(ALMOST_FULL_LVL);
   assign almost_empty = count <= CW'(ALMOST_EMPTY_LVL);
   always_comb begin
      m       = empty ? mode : mode_q;
      lifo    = m == MODE_LIFO;
      pop_ok  = pop & ~empty;
      push_ok = push & (~full | pop_ok);
      top_ptr = wr_ptr - PW'(1);
      // LIFO push+pop overwrites the current top in place
      waddr   = lifo && pop_ok ? top_ptr : wr_ptr;
      raddr   = lifo ? top_ptr : rd_ptr;
      wr_next = lifo && pop_ok ? (push_ok ? wr_ptr : top_ptr) : push_ok ? wr_ptr + PW'(1) : wr_ptr;
      // tracking wr_ptr while empty keeps the queue head aligned after a mode switch
      rd_next = empty ? wr_ptr : !lifo && pop_ok ? rd_ptr + PW'(1) : rd_ptr;
   end
   stack_queue_mem #(.BUS_WIDTH(BUS_WIDTH), .STACK_SIZE(STACK_SIZE)) u_mem (
      .clk   (clk),
      .we    (push_ok & ~reset),
      .waddr (waddr),
      .raddr (raddr),
      .wdata (data_in),
      .rdata (rdata)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         mode_q    <= MODE_LIFO;
         data_out  <= '0;
         valid     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ptr    <= wr_next;
         rd_ptr    <= rd_next;
         count     <= count + CW'(push_ok) - CW'(pop_ok);
         mode_q    <= m;
         valid     <= pop_ok;
         overflow  <= push & ~push_ok;
         underflow <= pop & ~pop_ok;
         if (pop_ok) data_out <= rdata;
      end
   end
endmodule

// File: tb/tb_stack_queue.sv
// tb_stack_queue: directed vector bench for stack_queue with BUS_WIDTH=8, STACK_SIZE=4
module tb_stack_queue;
   localparam int BW = 8;
   localparam int SS = 4;
   logic clk = 1'b0;
   logic reset, mode, push, pop;
   logic [BW-1:0] data_in, data_out;
   logic valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [2:0] count;
   int applied = 0;
   int miscompares = 0;
   typedef struct {
      logic r, m, pu, po;
      logic [7:0] din, edo;
      logic ev;
      int ec;
      logic eo, eu;
   } vec_t;
   vec_t vecs[$];
   always #5 clk = ~clk;
   stack_queue #(.BUS_WIDTH(BW), .STACK_SIZE(SS)) dut (
      .clk          (clk),
      .reset        (reset),
      .mode         (mode),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .data_out     (data_out),
      .valid        (valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );
   task automatic add(input logic r, m, pu, po, input logic [7:0] din, edo,
                      input logic ev, input int ec, input logic eo, eu);
      vec_t t;
      t.r = r; t.m = m; t.pu = pu; t.po = po; t.din = din; t.edo = edo;
      t.ev = ev; t.ec = ec; t.eo = eo; t.eu = eu;
      vecs.push_back(t);
   endtask
   task automatic step(input logic r, m, pu, po, input logic [7:0] din);
      reset = r; mode = m; push = pu; pop = po; data_in = din;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic check(input string nm, input logic [7:0] edo, input logic ev,
                        input int ec, input logic eo, eu);
      logic [17:0] got, exp;
      got = {data_out, valid, count, full, empty, almost_full, almost_empty, overflow, underflow};
      exp = {edo, ev, 3'(ec), ec == SS, ec == 0, ec >= SS - 2, ec <= 2, eo, eu};
      applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got do=%h v=%b cnt=%0d f/e/af/ae=%b%b%b%b ovf=%b udf=%b; expected do=%h v=%b cnt=%0d f/e/af/ae=%b%b%b%b ovf=%b udf=%b",
                  nm, data_out, valid, count, full, empty, almost_full, almost_empty, overflow, underflow,
                  edo, ev, ec, exp[5], exp[4], exp[3], exp[2], eo, eu);
      end
   endtask
   initial begin
      reset = 1'b1; mode = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
      //  r  m  pu po din    edo    v cnt ovf udf
      add(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 8'h11, 8'h00, 0, 1, 0, 0);
      add(0, 0, 1, 0, 8'h22, 8'h00, 0, 2, 0, 0);
      add(0, 0, 1, 0, 8'h33, 8'h00, 0, 3, 0, 0);
      add(0, 0, 1, 0, 8'h44, 8'h00, 0, 4, 0, 0);
      add(0, 0, 0, 1, 8'h00, 8'h44, 1, 3, 0, 0);
      add(0, 0, 0, 1, 8'h00, 8'h33, 1, 2, 0, 0);
      add(0, 0, 0, 1, 8'h00, 8'h22, 1, 1, 0, 0);
      add(0, 0, 0, 1, 8'h00, 8'h11, 1, 0, 0, 0);
      add(0, 0, 0, 0, 8'h00, 8'h11, 0, 0, 0, 0);
      add(0, 1, 1, 0, 8'h11, 8'h11, 0, 1, 0, 0);
      add(0, 1, 1, 0, 8'h22, 8'h11, 0, 2, 0, 0);
      add(0, 1, 1, 0, 8'h33, 8'h11, 0, 3, 0, 0);
      add(0, 1, 1, 0, 8'h44, 8'h11, 0, 4, 0, 0);
      add(0, 1, 1, 0, 8'h55, 8'h11, 0, 4, 1, 0);
      add(0, 1, 1, 1, 8'hAA, 8'h11, 1, 4, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'h22, 1, 3, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'h33, 1, 2, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'h44, 1, 1, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'hAA, 1, 0, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'hAA, 0, 0, 0, 1);
      add(0, 1, 1, 1, 8'hBB, 8'hAA, 0, 1, 0, 1);
      add(0, 1, 0, 1, 8'h00, 8'hBB, 1, 0, 0, 0);
      add(0, 0, 1, 0, 8'h11, 8'hBB, 0, 1, 0, 0);
      add(0, 0, 1, 0, 8'h22, 8'hBB, 0, 2, 0, 0);
      add(0, 0, 1, 1, 8'h99, 8'h22, 1, 2, 0, 0);
      add(0, 0, 0, 1, 8'h00, 8'h99, 1, 1, 0, 0);
      add(0, 0, 0, 1, 8'h00, 8'h11, 1, 0, 0, 0);
      add(0, 0, 1, 0, 8'h11, 8'h11, 0, 1, 0, 0);
      add(0, 1, 1, 0, 8'h22, 8'h11, 0, 2, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'h22, 1, 1, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'h11, 1, 0, 0, 0);
      add(0, 1, 1, 0, 8'hA1, 8'h11, 0, 1, 0, 0);
      add(0, 1, 1, 0, 8'hA2, 8'h11, 0, 2, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'hA1, 1, 1, 0, 0);
      add(0, 1, 0, 1, 8'h00, 8'hA2, 1, 0, 0, 0);
      add(0, 0, 1, 0, 8'h01, 8'hA2, 0, 1, 0, 0);
      add(0, 0, 1, 0, 8'h02, 8'hA2, 0, 2, 0, 0);
      add(0, 0, 1, 0, 8'h03, 8'hA2, 0, 3, 0, 0);
      add(1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
      add(0, 0, 1, 0, 8'h77, 8'h00, 0, 1, 0, 0);
      add(0, 0, 0, 1, 8'h00, 8'h77, 1, 0, 0, 0);
      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].m, vecs[i].pu, vecs[i].po, vecs[i].din);
         check($sformatf("vec%0d", i), vecs[i].edo, vecs[i].ev, vecs[i].ec, vecs[i].eo, vecs[i].eu);
      end
      // FIFO streaming through enough words to wrap both pointers
      step(0, 1, 1, 0, 8'hC0);
      check("wrap_push0", 8'h77, 0, 1, 0, 0);
      step(0, 1, 1, 0, 8'hC1);
      check("wrap_push1", 8'h77, 0, 2, 0, 0);
      for (int i = 2; i < 6; i++) begin
         logic [7:0] d;
         d = 8'hC0 + 8'(i);
         step(0, 1, 1, 1, d);
         check($sformatf("wrap_pp%0d", i), d - 8'd2, 1, 2, 0, 0);
      end
      step(0, 1, 0, 1, 8'h00);
      check("wrap_pop4", 8'hC4, 1, 1, 0, 0);
      step(0, 1, 0, 1, 8'h00);
      check("wrap_pop5", 8'hC5, 1, 0, 0, 0);
      step(0, 1, 0, 0, 8'h00);
      check("wrap_idle", 8'hC5, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule

// File: doc/stack_queue.md
Name: stack_queue

Overview:
Parametrised successor to the team's single-mode stack. Configurable-width, configurable-depth buffer that runs as a LIFO (stack) or FIFO (queue), selected per fill cycle. It has a registered pop-data return, occupancy count, full/empty/almost flags and overflow/underflow error pulses. It sits between data producers and consumers in the datapath, with everything on one rising clock edge.

Parameters:
BUS_WIDTH, 16, data word width in bits (>=1)
STACK_SIZE, 16, number of entries; power of 2, >=2
ALMOST_FULL_LVL, STACK_SIZE-2, almost_full asserted when count >= this value
ALMOST_EMPTY_LVL, 2, almost_empty asserted when count <= this value

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
mode  in  1  0 = LIFO, 1 = FIFO; sampled only while empty
push  in  1  write request
pop  in  1  read request
data_in  in  BUS_WIDTH  write data
data_out  out  BUS_WIDTH  registered read data
valid  out  1  1-cycle pulse: data_out holds an accepted pop
count  out  $clog2(STACK_SIZE)+1  occupancy, 0..STACK_SIZE
full  out  1  count == STACK_SIZE
empty  out  1  count == 0
almost_full  out  1  count >= ALMOST_FULL_LVL
almost_empty  out  1  count <= ALMOST_EMPTY_LVL
overflow  out  1  1-cycle pulse: push rejected
underflow  out  1  1-cycle pulse: pop rejected

Behaviour:
- Reset (wins over push/pop): wr_ptr=0, rd_ptr=0, count=0, mode_q=0, data_out=0, valid=0, overflow=0, underflow=0. Memory contents are not reset. Flags are combinational from count, so after reset empty=1, almost_empty=1, full=0 and almost_full=0.
- Effective mode: m = (count==0) ? mode : mode_q. When count==0, mode_q <= mode. A mode change while non-empty is ignored.
- While count==0: rd_ptr <= wr_ptr, which aligns the queue head on a LIFO->FIFO switch.
- LIFO push: mem[wr_ptr] <= data_in, wr_ptr+1. LIFO pop: data_out <= mem[wr_ptr-1], wr_ptr-1.
- FIFO push: mem[wr_ptr] <= data_in, wr_ptr+1. FIFO pop: data_out <= mem[rd_ptr], rd_ptr+1.
- Pointers are $clog2(STACK_SIZE) bits wide and wrap modulo STACK_SIZE.
- Pop latency is 1: pop accepted at edge N means data_out and valid=1 are visible after edge N. data_out holds its value until the next accepted pop.
- Acceptance rules:
  - empty, push only: push accepted.
  - empty, pop (with or without push): pop rejected, underflow=1; any push is still accepted.
  - full, push only: push rejected, overflow=1, state unchanged.
  - full, push+pop: both accepted.
  - otherwise: requests accepted as issued.
- Simultaneous push+pop, non-empty:
  - LIFO replace-top: data_out <= mem[wr_ptr-1], mem[wr_ptr-1] <= data_in, wr_ptr and count unchanged.
  - FIFO: read mem[rd_ptr] and write mem[wr_ptr] in the same edge; both pointers advance; count unchanged. When full, rd_ptr==wr_ptr and the read returns the old value (read-before-write).
- count: +1 on accepted push only, -1 on accepted pop only, unchanged otherwise. Never exceeds STACK_SIZE and never goes below 0.
- overflow and underflow are single-cycle pulses, never sticky.
- Reset mid-operation: the next cycle behaves as post-reset. A pop issued in the reset cycle produces neither valid nor underflow.

Decomposition:
- Package stack_queue_pkg holds MODE_LIFO=1'b0 and MODE_FIFO=1'b1, plus the helper width function for the count and pointer widths.
- Sub-module stack_queue_mem: STACK_SIZE x BUS_WIDTH register file with one synchronous write port and one asynchronous read port. The parent registers the read into data_out.

Test Plan:
- BUS_WIDTH=8, STACK_SIZE=4, mode=0: push 0x11,0x22,0x33,0x44, then 4 pops -> data_out 0x44,0x33,0x22,0x11 with valid each pop cycle+1; full=1 after 4th push; empty=1 at end.
- mode=1, same pushes and pops -> data_out 0x11,0x22,0x33,0x44. Then push/pop 6 more words to force pointer wrap -> order preserved.
- Full (4 entries), push 0x55 -> overflow pulse, count=4; pops return the original contents. Empty, pop -> underflow pulse, valid=0, count=0.
- LIFO holding 0x11,0x22, push 0x99 + pop in the same cycle -> data_out=0x22, count=2; next pops give 0x99 then 0x11.
- LIFO holding 1 entry, set mode=1 -> mode ignored (LIFO order kept). Drain, then mode=1 with push 0xA1,0xA2 in the same cycle as the switch -> FIFO order 0xA1,0xA2.
- Push 3 words, assert reset together with pop -> count=0, empty=1, valid=0, underflow=0, data_out=0; then push 0x77 and pop -> 0x77.
